// File: rtl/sirv_gnrl_fifo.sv
// Generic synchronous FIFO with registered storage and no bypass path.
// An entry pushed on one edge is visible at o_dat from the following cycle.
module sirv_gnrl_fifo #(
  parameter int CUT_READY = 0,
  parameter int MSKO      = 0,
  parameter int DP        = 4,
  parameter int DW        = 33
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          i_vld,
  output logic          i_rdy,
  input  logic [DW-1:0] i_dat,
  output logic          o_vld,
  input  logic          o_rdy,
  output logic [DW-1:0] o_dat
);

  localparam int PW = (DP > 1) ? $clog2(DP) : 1;
  localparam int CW = $clog2(DP + 1);

  logic [DW-1:0] mem_q [DP];
  logic [PW-1:0] wptr;
  logic [PW-1:0] rptr;
  logic [CW-1:0] cnt;
  logic          full;
  logic          wen;
  logic          ren;

  assign full  = (cnt == CW'(DP));
  assign o_vld = (cnt != '0);
  assign ren   = o_vld & o_rdy;
  assign wen   = i_vld & i_rdy;

  generate
    if (CUT_READY != 0) begin : g_cut
      assign i_rdy = ~full;
    end else begin : g_nocut
      assign i_rdy = ~full | ren;
    end
  endgenerate

  generate
    if (MSKO != 0) begin : g_msk
      assign o_dat = o_vld ? mem_q[rptr] : '0;
    end else begin : g_nomsk
      assign o_dat = mem_q[rptr];
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
      for (int i = 0; i < DP; i++) mem_q[i] <= '0;
    end else begin
      if (wen) begin
        mem_q[wptr] <= i_dat;
        wptr        <= (wptr == PW'(DP - 1)) ? '0 : wptr + PW'(1);
      end
      if (ren) rptr <= (rptr == PW'(DP - 1)) ? '0 : rptr + PW'(1);
      case ({wen, ren})
        2'b10:   cnt <= cnt + CW'(1);
        2'b01:   cnt <= cnt - CW'(1);
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/e203_dma_icb2mem.sv
// DMA ICB slave to single-port SRAM bridge: window decode, one-cycle stage,
// and an in-order response FIFO guarded by a credit counter.
module e203_dma_icb2mem #(
  parameter int            AW        = 32,
  parameter int            DW        = 32,
  parameter int            MEM_AW    = 12,
  parameter logic [AW-1:0] BASE_ADDR = 32'h7000_0000,
  parameter int            RSP_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              icb_cmd_valid,
  output logic              icb_cmd_ready,
  input  logic [AW-1:0]     icb_cmd_addr,
  input  logic              icb_cmd_read,
  input  logic [DW-1:0]     icb_cmd_wdata,
  input  logic [DW/8-1:0]   icb_cmd_wmask,
  output logic              icb_rsp_valid,
  input  logic              icb_rsp_ready,
  output logic              icb_rsp_err,
  output logic [DW-1:0]     icb_rsp_rdata,
  output logic              mem_cs,
  output logic              mem_we,
  output logic [DW/8-1:0]   mem_wem,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [DW-1:0]     mem_din,
  input  logic [DW-1:0]     mem_dout
);

  localparam int CW = $clog2(RSP_DEPTH + 1);

  logic [CW-1:0] cnt;
  logic          hit;
  logic          cmd_hsk;
  logic          rsp_hsk;
  logic          stg_vld;
  logic          stg_read;
  logic          stg_err;
  logic          fifo_i_rdy;
  logic [DW:0]   fifo_i_dat;
  logic [DW:0]   fifo_o_dat;

  // Credits cover the stage register plus FIFO, so ready never depends on rsp_ready.
  assign icb_cmd_ready = (cnt < CW'(RSP_DEPTH));
  assign cmd_hsk       = icb_cmd_valid & icb_cmd_ready;
  assign rsp_hsk       = icb_rsp_valid & icb_rsp_ready;

  assign hit = (icb_cmd_addr[AW-1:MEM_AW+2] == BASE_ADDR[AW-1:MEM_AW+2])
             && (icb_cmd_addr[1:0] == 2'b00);

  assign mem_cs   = cmd_hsk & hit;
  assign mem_we   = ~icb_cmd_read;
  assign mem_wem  = icb_cmd_wmask;
  assign mem_addr = icb_cmd_addr[MEM_AW+1:2];
  assign mem_din  = icb_cmd_wdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (cmd_hsk & ~rsp_hsk) begin
      cnt <= cnt + CW'(1);
    end else if (~cmd_hsk & rsp_hsk) begin
      cnt <= cnt - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stg_vld  <= 1'b0;
      stg_read <= 1'b0;
      stg_err  <= 1'b0;
    end else begin
      stg_vld <= cmd_hsk;
      if (cmd_hsk) begin
        stg_read <= icb_cmd_read;
        stg_err  <= ~hit;
      end
    end
  end

  // mem_dout is valid in the stage cycle; capture it straight into the FIFO.
  assign fifo_i_dat = {stg_err, (stg_read & ~stg_err) ? mem_dout : {DW{1'b0}}};

  sirv_gnrl_fifo #(
    .CUT_READY (0),
    .MSKO      (0),
    .DP        (RSP_DEPTH),
    .DW        (DW + 1)
  ) u_rsp_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .i_vld (stg_vld),
    .i_rdy (fifo_i_rdy),
    .i_dat (fifo_i_dat),
    .o_vld (icb_rsp_valid),
    .o_rdy (icb_rsp_ready),
    .o_dat (fifo_o_dat)
  );

  assign icb_rsp_err   = fifo_o_dat[DW];
  assign icb_rsp_rdata = fifo_o_dat[DW-1:0];

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) stg_vld |-> fifo_i_rdy);

endmodule

// File: doc/e203_dma_icb2mem.md
Name: e203_dma_icb2mem

Overview:
- ICB slave bridge directly downstream of the SoC DMA ICB master port (dma_icb_*); converts DMA ICB commands into a single-port synchronous SRAM access port (MVU scratchpad / activation memory).
- Decodes a fixed address window, drives the memory port, and returns in-order ICB responses through a small response FIFO with credit-based backpressure.
- Error responses are generated for out-of-window or misaligned accesses without touching memory.

Parameters:
- AW, 32, ICB address width (`E203_ADDR_SIZE).
- DW, 32, ICB data width (`E203_XLEN); byte mask width DW/8.
- MEM_AW, 12, memory word-address width (window = 2^MEM_AW words = 16 KiB at default).
- BASE_ADDR, 32'h7000_0000, window base; must be aligned to window size.
- RSP_DEPTH, 4, response FIFO depth / max outstanding commands; must be >= 3 for full throughput.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- icb_cmd_valid  in  1  command valid
- icb_cmd_ready  out  1  command ready
- icb_cmd_addr  in  AW  byte address
- icb_cmd_read  in  1  1=read, 0=write
- icb_cmd_wdata  in  DW  write data
- icb_cmd_wmask  in  DW/8  byte write enables
- icb_rsp_valid  out  1  response valid
- icb_rsp_ready  in  1  response ready
- icb_rsp_err  out  1  response error
- icb_rsp_rdata  out  DW  read data (0 on writes/errors)
- mem_cs  out  1  memory chip select
- mem_we  out  1  memory write enable
- mem_wem  out  DW/8  memory byte write enables
- mem_addr  out  MEM_AW  memory word address
- mem_din  out  DW  memory write data
- mem_dout  in  DW  memory read data, valid one cycle after mem_cs with mem_we=0

Behaviour:
- Clock/reset: single clock clk; reset rst_n is asynchronous, active-low.
- Reset: credit counter=0, stage register invalid, FIFO empty; icb_rsp_valid=0, icb_rsp_err=0, icb_rsp_rdata=0; icb_cmd_ready=1 after reset; mem_cs=0 while icb_cmd_valid=0.
- Credits: cnt increments on cmd handshake, decrements on rsp handshake; both in the same cycle leaves cnt unchanged. icb_cmd_ready = (cnt < RSP_DEPTH); it is registered-state only, with no combinational path from icb_rsp_ready.
- Decode: hit = addr[AW-1:MEM_AW+2]==BASE_ADDR[AW-1:MEM_AW+2] && addr[1:0]==0. mem_addr = addr[MEM_AW+1:2].
- Memory drive (combinational from cmd):
  - mem_cs = icb_cmd_valid & icb_cmd_ready & hit.
  - mem_we = ~icb_cmd_read.
  - mem_wem = icb_cmd_wmask.
  - mem_din = icb_cmd_wdata.
  - A write with wmask=0 still asserts mem_cs with mem_wem=0.
- Miss: no mem_cs; response err=1, rdata=0.
- Pipeline: the accepted command at cycle T loads the stage register {is_read, err}. At T+1 the FIFO is written with {err, (is_read & ~err) ? mem_dout : 0}. icb_rsp_valid is asserted no earlier than T+2.
- Latency: fixed 2-cycle minimum for both reads and writes. Responses are strictly in command order.
- Throughput: one command per cycle sustained when icb_rsp_ready=1 and RSP_DEPTH>=3.
- Backpressure: icb_rsp_ready=0 fills the FIFO; cmd_ready drops when cnt reaches RSP_DEPTH. Credits guarantee the FIFO never overflows; writing to a full FIFO is an assertion failure.
- Simultaneous FIFO push and pop when full: cannot occur by construction. Push and pop when not full: both take effect.
- Reset mid-operation: all in-flight responses are discarded; memory contents are unaffected.

Decomposition:
- No package. Width and BASE_ADDR come from e203 config defines / parameters.
- One sub-module: response FIFO, reusing sirv_gnrl_fifo (CUT_READY=0, MSKO=0, DP=RSP_DEPTH, DW=DW+1).
- Credit counter, decode and stage register live in the top.

Test Plan:
- Write addr 0x7000_0010, wdata 0xDEADBEEF, wmask 4'hF -> mem_cs=1, mem_we=1, mem_addr=4 in the same cycle; rsp at T+2 with err=0, rdata=0.
- Read addr 0x7000_0010 with mem model returning 0xDEADBEEF -> mem_cs=1, mem_we=0; rsp at T+2 with rdata=0xDEADBEEF, err=0.
- Read addr 0x6000_0000 and read addr 0x7000_0002 -> mem_cs never asserted; each rsp has err=1, rdata=0.
- 16 back-to-back reads with icb_rsp_ready=1 -> cmd_ready stays 1; 16 responses on consecutive cycles, in order.
- icb_rsp_ready=0, issue 6 writes -> exactly 4 accepted, cmd_ready=0 after the 4th; raise rsp_ready -> 4 responses, then the remaining 2 are accepted.
- Assert rst_n=0 with 3 responses pending -> rsp_valid=0 immediately; after release cnt=0, cmd_ready=1, no stale responses appear.
